// File: rtl/pipe_sequencer.sv
// pipe_sequencer: control sequencer for a 2-stage pipeline
// (fetch/decode/execute | mem/writeback) on a synchronous imem.
// Ports:
//   clk, reset (sync, active-low)
//   dec_redirect, dec_src1, dec_src2        stage-1 status
//   ex_regWrtEn, ex_regWrtIdx, ex_memtoReg,
//   ex_memAccess, mem_ready                 stage-2 status
//   dbg_halt, dbg_step                      debug control
//   pcWrtEn, pipeWrtEn, pipeFlush           pipe control
//   fwdSel1, fwdSel2                        forwarding selects
//   state, stallCount, memTimeout           status
module pipe_sequencer #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int CNT_BITS            = 16,
    parameter int TO_BITS             = 8,
    parameter int MEM_TIMEOUT         = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dec_redirect,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2,
    input  logic                           ex_regWrtEn,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_regWrtIdx,
    input  logic                           ex_memtoReg,
    input  logic                           ex_memAccess,
    input  logic                           mem_ready,
    input  logic                           dbg_halt,
    input  logic                           dbg_step,
    output logic                           pcWrtEn,
    output logic                           pipeWrtEn,
    output logic                           pipeFlush,
    output logic [1:0]                     fwdSel1,
    output logic [1:0]                     fwdSel2,
    output logic [1:0]                     state,
    output logic [CNT_BITS-1:0]            stallCount,
    output logic                           memTimeout
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FLUSH   = 2'b01,
        MEMWAIT = 2'b10,
        HALT    = 2'b11
    } state_t;

    localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(MEM_TIMEOUT);

    state_t             cur;
    state_t             nxt;
    logic [TO_BITS-1:0] wait_cnt;
    logic               step_q;
    logic               stall;
    logic               step_edge;
    logic               run_eval;
    logic               busy1;
    logic               busy2;
    logic               wait_clr;
    logic               wait_inc;
    logic               set_to;

    assign busy1   = ex_regWrtEn & (dec_src1 == ex_regWrtIdx);
    assign busy2   = ex_regWrtEn & (dec_src2 == ex_regWrtIdx);
    assign fwdSel1 = {busy1, busy1 & ex_memtoReg};
    assign fwdSel2 = {busy2, busy2 & ex_memtoReg};

    assign stall     = ex_memAccess & ~mem_ready;
    assign step_edge = dbg_step & ~step_q;
    // A step edge in HALT runs one normal RUN cycle.
    assign run_eval  = (cur == RUN) | ((cur == HALT) & step_edge);
    assign state     = cur;

    always_comb begin
        nxt       = cur;
        pcWrtEn   = 1'b0;
        pipeWrtEn = 1'b1;
        pipeFlush = 1'b1;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        set_to    = 1'b0;
        if (!reset) begin
            nxt = RUN;
        end else if (run_eval) begin
            if (stall) begin
                pipeWrtEn = 1'b0;
                pipeFlush = 1'b0;
                wait_clr  = 1'b1;
                nxt       = MEMWAIT;
            end else if (dec_redirect) begin
                pcWrtEn   = 1'b1;
                pipeFlush = 1'b0;
                nxt       = FLUSH;
            end else if (dbg_halt && cur == RUN) begin
                // Drain stage 2 and hold the stage-1 instruction.
                nxt = HALT;
            end else begin
                pcWrtEn   = 1'b1;
                pipeFlush = 1'b0;
                nxt       = RUN;
            end
        end else begin
            unique case (cur)
                FLUSH: begin
                    pcWrtEn = 1'b1;
                    nxt     = RUN;
                end
                MEMWAIT: begin
                    pipeFlush = 1'b0;
                    wait_inc  = 1'b1;
                    if (mem_ready || wait_cnt == TO_LIMIT) begin
                        // On timeout the pipe advances anyway.
                        pcWrtEn = 1'b1;
                        set_to  = ~mem_ready;
                        nxt     = dec_redirect ? FLUSH : RUN;
                    end else begin
                        pipeWrtEn = 1'b0;
                    end
                end
                HALT: begin
                    if (!dbg_halt) begin
                        nxt = RUN;
                    end
                end
                default: begin
                    nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur        <= RUN;
            stallCount <= '0;
            memTimeout <= 1'b0;
            wait_cnt   <= '0;
            step_q     <= 1'b0;
        end else begin
            cur    <= nxt;
            step_q <= dbg_step;
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (set_to) begin
                memTimeout <= 1'b1;
            end
            // HALT and the FLUSH bubble are not stalls.
            if (!pcWrtEn && cur != HALT && stallCount != '1) begin
                stallCount <= stallCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed and random checks of pipe_sequencer
// against a flag-based behavioural model.
module tb_pipe_sequencer;

    localparam int RIW  = 4;
    localparam int CNTB = 16;
    localparam int TOB  = 8;
    localparam int MTO  = 255;
    localparam int CMAX = 65535;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            dec_redirect = 1'b0;
    logic [RIW-1:0]  dec_src1 = '0;
    logic [RIW-1:0]  dec_src2 = '0;
    logic            ex_regWrtEn = 1'b0;
    logic [RIW-1:0]  ex_regWrtIdx = '0;
    logic            ex_memtoReg = 1'b0;
    logic            ex_memAccess = 1'b0;
    logic            mem_ready = 1'b1;
    logic            dbg_halt = 1'b0;
    logic            dbg_step = 1'b0;
    logic            pcWrtEn;
    logic            pipeWrtEn;
    logic            pipeFlush;
    logic [1:0]      fwdSel1;
    logic [1:0]      fwdSel2;
    logic [1:0]      state;
    logic [CNTB-1:0] stallCount;
    logic            memTimeout;

    pipe_sequencer #(
        .REG_INDEX_BIT_WIDTH(RIW),
        .CNT_BITS(CNTB),
        .TO_BITS(TOB),
        .MEM_TIMEOUT(MTO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dec_redirect(dec_redirect),
        .dec_src1(dec_src1),
        .dec_src2(dec_src2),
        .ex_regWrtEn(ex_regWrtEn),
        .ex_regWrtIdx(ex_regWrtIdx),
        .ex_memtoReg(ex_memtoReg),
        .ex_memAccess(ex_memAccess),
        .mem_ready(mem_ready),
        .dbg_halt(dbg_halt),
        .dbg_step(dbg_step),
        .pcWrtEn(pcWrtEn),
        .pipeWrtEn(pipeWrtEn),
        .pipeFlush(pipeFlush),
        .fwdSel1(fwdSel1),
        .fwdSel2(fwdSel2),
        .state(state),
        .stallCount(stallCount),
        .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: squash bubble pending, waiting on memory,
    // halted, plus counters.
    bit m_bubble, m_wait, m_halt, m_to, m_stepq;
    int m_waited, m_stalls;
    bit n_bubble, n_wait, n_halt, n_to, n_stepq;
    int n_waited, n_stalls;
    logic       e_pc, e_pipe, e_flush;
    logic [1:0] e_state, e_f1, e_f2;

    task automatic model_eval();
        bit stl, stp, adv;
        stl = ex_memAccess && !mem_ready;
        stp = dbg_step && !m_stepq;
        n_bubble = 0;
        n_wait   = m_wait;
        n_waited = m_waited;
        n_halt   = m_halt;
        n_to     = m_to;
        n_stepq  = dbg_step;
        n_stalls = m_stalls;
        e_pc     = 0;
        e_pipe   = 1;
        e_flush  = 1;
        e_state  = m_halt ? 2'd3 : m_wait ? 2'd2 :
                   m_bubble ? 2'd1 : 2'd0;
        e_f1 = 2'd0;
        e_f2 = 2'd0;
        if (ex_regWrtEn && dec_src1 == ex_regWrtIdx)
            e_f1 = ex_memtoReg ? 2'd3 : 2'd2;
        if (ex_regWrtEn && dec_src2 == ex_regWrtIdx)
            e_f2 = ex_memtoReg ? 2'd3 : 2'd2;
        if (!reset) begin
            n_wait   = 0;
            n_waited = 0;
            n_halt   = 0;
            n_to     = 0;
            n_stepq  = 0;
            n_stalls = 0;
        end else if (m_bubble) begin
            e_pc = 1;
        end else if (m_wait) begin
            adv = mem_ready || m_waited == MTO;
            e_flush = 0;
            if (adv) begin
                e_pc     = 1;
                n_wait   = 0;
                n_bubble = dec_redirect;
                if (!mem_ready) n_to = 1;
            end else begin
                e_pipe   = 0;
                n_waited = m_waited + 1;
            end
        end else if (m_halt && !stp) begin
            n_halt = dbg_halt;
        end else begin
            n_halt = 0;
            if (stl) begin
                e_pipe   = 0;
                e_flush  = 0;
                n_wait   = 1;
                n_waited = 0;
            end else if (dec_redirect) begin
                e_pc     = 1;
                e_flush  = 0;
                n_bubble = 1;
            end else if (dbg_halt && !m_halt) begin
                n_halt = 1;
            end else begin
                e_pc    = 1;
                e_flush = 0;
            end
        end
        if (reset && !e_pc && !m_halt && m_stalls < CMAX)
            n_stalls = m_stalls + 1;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic clk_edge();
        @(posedge clk);
        m_bubble = n_bubble;
        m_wait   = n_wait;
        m_waited = n_waited;
        m_halt   = n_halt;
        m_to     = n_to;
        m_stepq  = n_stepq;
        m_stalls = n_stalls;
        @(negedge clk);
    endtask

    task automatic idle();
        dec_redirect = 0;
        ex_regWrtEn  = 0;
        ex_memtoReg  = 0;
        ex_memAccess = 0;
        mem_ready    = 1;
        dbg_halt     = 0;
        dbg_step     = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        settle();
        clk_edge();
        settle();
        total++;
        if (pcWrtEn !== 1'b0 || pipeWrtEn !== 1'b1 ||
            pipeFlush !== 1'b1) begin
            $display("FAIL reset_ctl: got pc=%b pipe=%b flush=%b need 0 1 1",
                     pcWrtEn, pipeWrtEn, pipeFlush);
        end else passed++;
        clk_edge();
        reset = 1;
        settle();
        total++;
        if (state !== 2'd0 || stallCount !== '0 ||
            memTimeout !== 1'b0) begin
            $display("FAIL reset_state: got st=%0d cnt=%0d to=%b need 0 0 0",
                     state, stallCount, memTimeout);
        end else passed++;
    endtask

    task automatic test_run();
        idle();
        for (int i = 0; i < 5; i++) begin
            settle();
            total++;
            if (pcWrtEn !== 1'b1 || state !== 2'd0 ||
                stallCount !== '0) begin
                $display("FAIL run_%0d: got pc=%b st=%0d cnt=%0d need 1 0 0",
                         i, pcWrtEn, state, stallCount);
            end else passed++;
            clk_edge();
        end
    endtask

    task automatic test_redirect();
        idle();
        dec_redirect = 1;
        settle();
        total++;
        if (pcWrtEn !== 1'b1 || pipeFlush !== 1'b0) begin
            $display("FAIL redir_issue: got pc=%b flush=%b need 1 0",
                     pcWrtEn, pipeFlush);
        end else passed++;
        clk_edge();
        settle();
        total++;
        if (state !== 2'd1 || pipeFlush !== 1'b1 ||
            pcWrtEn !== 1'b1) begin
            $display("FAIL redir_flush: got st=%0d flush=%b pc=%b need 1 1 1",
                     state, pipeFlush, pcWrtEn);
        end else passed++;
        clk_edge();
        dec_redirect = 0;
        settle();
        total++;
        if (state !== 2'd0 || pipeFlush !== 1'b0) begin
            $display("FAIL redir_back: got st=%0d flush=%b need 0 0",
                     state, pipeFlush);
        end else passed++;
        clk_edge();
    endtask

    task automatic test_memwait(input bit redir, input int need);
        int lows;
        idle();
        dec_redirect = redir;
        ex_memAccess = 1;
        mem_ready    = 0;
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (pcWrtEn === 1'b0 && pipeWrtEn === 1'b0) lows++;
            clk_edge();
        end
        total++;
        if (lows != 3) begin
            $display("FAIL memwait_stall r%0d: got %0d frozen need 3",
                     redir, lows);
        end else passed++;
        mem_ready = 1;
        settle();
        total++;
        if (pcWrtEn !== 1'b1 || state !== 2'd2) begin
            $display("FAIL memwait_ready r%0d: got pc=%b st=%0d need 1 2",
                     redir, pcWrtEn, state);
        end else passed++;
        clk_edge();
        idle();
        settle();
        total++;
        if (state !== (redir ? 2'd1 : 2'd0) ||
            pipeFlush !== redir ||
            stallCount !== 16'(need)) begin
            $display("FAIL memwait_after r%0d: got st=%0d fl=%b cnt=%0d need %0d %b %0d",
                     redir, state, pipeFlush, stallCount,
                     redir ? 1 : 0, redir, need);
        end else passed++;
        clk_edge();
        settle();
        clk_edge();
    endtask

    task automatic test_forwarding();
        idle();
        ex_regWrtEn  = 1;
        ex_regWrtIdx = 5;
        dec_src1     = 5;
        dec_src2     = 3;
        ex_memtoReg  = 1;
        settle();
        total++;
        if (fwdSel1 !== 2'b11 || fwdSel2 !== 2'b00) begin
            $display("FAIL fwd_load: got %b %b need 11 00",
                     fwdSel1, fwdSel2);
        end else passed++;
        ex_memtoReg = 0;
        dec_src2    = 5;
        settle();
        total++;
        if (fwdSel1 !== 2'b10 || fwdSel2 !== 2'b10) begin
            $display("FAIL fwd_alu: got %b %b need 10 10",
                     fwdSel1, fwdSel2);
        end else passed++;
        ex_regWrtEn = 0;
        ex_memtoReg = 1;
        dec_src2    = 3;
        settle();
        total++;
        if (fwdSel1 !== 2'b00 || fwdSel2 !== 2'b00) begin
            $display("FAIL fwd_off: got %b %b need 00 00",
                     fwdSel1, fwdSel2);
        end else passed++;
        clk_edge();
        idle();
    endtask

    task automatic test_halt_step();
        int ups;
        idle();
        dbg_halt = 1;
        settle();
        total++;
        if (pcWrtEn !== 1'b0 || pipeFlush !== 1'b1 ||
            state !== 2'd0) begin
            $display("FAIL halt_enter: got pc=%b fl=%b st=%0d need 0 1 0",
                     pcWrtEn, pipeFlush, state);
        end else passed++;
        clk_edge();
        settle();
        total++;
        if (state !== 2'd3 || pcWrtEn !== 1'b0) begin
            $display("FAIL halt_hold: got st=%0d pc=%b need 3 0",
                     state, pcWrtEn);
        end else passed++;
        ups = 0;
        for (int i = 0; i < 12; i++) begin
            dbg_step = (i == 1 || i == 5);
            settle();
            if (pcWrtEn === 1'b1) ups++;
            clk_edge();
        end
        total++;
        if (ups != 2) begin
            $display("FAIL step_pulses: got %0d advances need 2", ups);
        end else passed++;
        ups = 0;
        for (int i = 0; i < 10; i++) begin
            dbg_step = (i >= 1);
            settle();
            if (pcWrtEn === 1'b1) ups++;
            clk_edge();
        end
        total++;
        if (ups != 1) begin
            $display("FAIL step_held: got %0d advances need 1", ups);
        end else passed++;
        settle();
        total++;
        if (state !== 2'd3 || stallCount !== 16'(m_stalls)) begin
            $display("FAIL halt_cnt: got st=%0d cnt=%0d need 3 %0d",
                     state, stallCount, m_stalls);
        end else passed++;
        dbg_halt = 0;
        dbg_step = 0;
        settle();
        clk_edge();
        settle();
        total++;
        if (state !== 2'd0 || pcWrtEn !== 1'b1) begin
            $display("FAIL halt_exit: got st=%0d pc=%b need 0 1",
                     state, pcWrtEn);
        end else passed++;
        clk_edge();
    endtask

    task automatic test_timeout();
        int lows;
        idle();
        ex_memAccess = 1;
        mem_ready    = 0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            settle();
            if (pcWrtEn === 1'b1) break;
            lows++;
            clk_edge();
        end
        total++;
        if (lows != MTO + 1 || memTimeout !== 1'b0) begin
            $display("FAIL timeout_len: got %0d stalls to=%b need %0d 0",
                     lows, memTimeout, MTO + 1);
        end else passed++;
        clk_edge();
        idle();
        for (int i = 0; i < 5; i++) begin
            settle();
            clk_edge();
        end
        settle();
        total++;
        if (memTimeout !== 1'b1 ||
            stallCount !== 16'(m_stalls)) begin
            $display("FAIL timeout_sticky: got to=%b cnt=%0d need 1 %0d",
                     memTimeout, stallCount, m_stalls);
        end else passed++;
    endtask

    task automatic test_reset_mid_wait();
        idle();
        ex_memAccess = 1;
        mem_ready    = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            clk_edge();
        end
        reset = 0;
        settle();
        total++;
        if (state !== 2'd2 || pcWrtEn !== 1'b0 ||
            pipeWrtEn !== 1'b1 || pipeFlush !== 1'b1) begin
            $display("FAIL rst_wait_ctl: got st=%0d pc=%b pw=%b fl=%b need 2 0 1 1",
                     state, pcWrtEn, pipeWrtEn, pipeFlush);
        end else passed++;
        clk_edge();
        reset = 1;
        idle();
        settle();
        total++;
        if (state !== 2'd0 || stallCount !== '0 ||
            memTimeout !== 1'b0 || pcWrtEn !== 1'b1) begin
            $display("FAIL rst_wait_clr: got st=%0d cnt=%0d to=%b pc=%b need 0 0 0 1",
                     state, stallCount, memTimeout, pcWrtEn);
        end else passed++;
        clk_edge();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 149) != 0);
            dec_redirect = ($urandom_range(0, 3) == 0);
            ex_memAccess = ($urandom_range(0, 2) == 0);
            mem_ready    = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0) dbg_halt = ~dbg_halt;
            dbg_step     = ($urandom_range(0, 2) == 0);
            ex_regWrtEn  = $urandom_range(0, 1);
            ex_memtoReg  = $urandom_range(0, 1);
            ex_regWrtIdx = RIW'($urandom_range(0, 3));
            dec_src1     = RIW'($urandom_range(0, 3));
            dec_src2     = RIW'($urandom_range(0, 3));
            settle();
            total++;
            if (pcWrtEn !== e_pc || pipeWrtEn !== e_pipe ||
                pipeFlush !== e_flush || state !== e_state ||
                fwdSel1 !== e_f1 || fwdSel2 !== e_f2 ||
                stallCount !== 16'(m_stalls) ||
                memTimeout !== m_to) begin
                $display("FAIL rand_%0d: got pc%b pw%b fl%b st%0d f%b/%b c%0d t%b need pc%b pw%b fl%b st%0d f%b/%b c%0d t%b",
                         i, pcWrtEn, pipeWrtEn, pipeFlush, state,
                         fwdSel1, fwdSel2, stallCount, memTimeout,
                         e_pc, e_pipe, e_flush, e_state,
                         e_f1, e_f2, m_stalls, m_to);
            end else passed++;
            clk_edge();
        end
        reset = 1;
        idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_redirect();
        test_memwait(1'b0, 3);
        test_memwait(1'b1, 6);
        test_forwarding();
        test_halt_step();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
